// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the memory responder
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_BAD = 2'd2
  } op_e;

  function automatic op_e decode_op(input logic rd, input logic wr);
    if (rd && wr) return OP_BAD;
    else if (wr) return OP_WR;
    else return OP_RD;
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM with registered read data
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents survive reset, but a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst && we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) rdata_q <= '0;
    else if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated memory responder; MEM_BOUNDS_CHECK_EN enables address bounds errors
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [32:0] DEPTH_L = 33'(DEPTH);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  op_e               op_q, op_d;
  logic              ready_q, err_q;
  logic              oob;
  logic [AW-1:0]     mem_idx;
  logic              mem_we, mem_re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = decode_op(MemRead, MemWrite);
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else cnt_d = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  always_comb begin
    oob     = (33'(addr_q) >= DEPTH_L);
    mem_idx = AW'(addr_q);
  end
`else
  always_comb begin
    oob     = 1'b0;
    mem_idx = AW'(33'(addr_q) % DEPTH_L);
  end
`endif

  // The RAM access happens on the edge leaving RESP, together with ready.
  assign mem_we = (state_q == RESP) && (op_q == OP_WR) && !oob;
  assign mem_re = (state_q == RESP) && (op_q == OP_RD) && !oob;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      ready_q <= (state_q == RESP);
      err_q   <= (state_q == RESP) && ((op_q == OP_BAD) || oob);
    end
  end

  mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_idx),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized scoreboard bench for mem_responder
module tb_mem_responder;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mr [2];
  logic        mw [2];
  logic [11:0] ad [2];
  logic [15:0] wd [2];
  logic [15:0] rd_o [2];
  logic        rdy [2];
  logic        er [2];

  int total = 0;
  int bad = 0;

  logic [15:0] mm [2][4096];
  bit          mv [2][4096];
  logic [15:0] exp_rd [2];
  bit          exp_known [2];

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]),
    .wdata(wd[0]), .rdata(rd_o[0]), .ready(rdy[0]), .err(er[0])
  );

  mem_responder #(.DATA_W(16), .ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]),
    .wdata(wd[1]), .rdata(rd_o[1]), .ready(rdy[1]), .err(er[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic access(input int k, input bit r, input bit w, input logic [11:0] a,
                        input logic [15:0] d, input bit drop);
    int  wc    = (k == 0) ? 2 : 0;
    int  depth = (k == 0) ? 4096 : 1024;
    int  idx   = int'(a) % depth;
    bit  oob   = BOUNDS && (int'(a) >= depth);
    bit  e_err = (r && w) || oob;
    int  lat   = -1;
    mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
    @(posedge clk); #1;
    if (drop) begin
      mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = 12'd9; wd[k] = 16'($urandom);
    end
    for (int i = 1; i <= wc + 4; i++) begin
      if (i > 1 || !drop || wc > 0 || !rdy[k]) begin
        @(posedge clk); #1;
      end
      if (rdy[k]) begin lat = i; break; end
    end
    mr[k] = 1'b0; mw[k] = 1'b0;
    if (!e_err) begin
      if (w) begin
        mm[k][idx] = d; mv[k][idx] = 1'b1;
      end else begin
        exp_rd[k] = mm[k][idx]; exp_known[k] = mv[k][idx];
      end
    end
    check($sformatf("lat%0d", k), lat, wc + 1);
    check($sformatf("err%0d", k), {31'd0, er[k]}, {31'd0, e_err});
    if (exp_known[k]) check($sformatf("rdata%0d@%0h", k, a), {16'd0, rd_o[k]}, {16'd0, exp_rd[k]});
    @(posedge clk); #1;
    check($sformatf("pulse%0d", k), {31'd0, rdy[k]}, 32'd0);
  endtask

  initial begin
    bit seen;
    logic [11:0] a;
    int p;
    for (int k = 0; k < 2; k++) begin
      mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = '0; wd[k] = '0;
      exp_rd[k] = '0; exp_known[k] = 1'b1;
      for (int j = 0; j < 4096; j++) mv[k][j] = 1'b0;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", {31'd0, rdy[k]}, 32'd0);
      check("rst_rdata", {16'd0, rd_o[k]}, 32'd0);
      check("rst_err", {31'd0, er[k]}, 32'd0);
    end
    rst = 1'b1;

    access(0, 0, 1, 12'd5, 16'hBEEF, 0);
    access(0, 1, 0, 12'd5, 16'h0000, 0);
    repeat (10) @(posedge clk);
    #1;
    check("hold_rdata", {16'd0, rd_o[0]}, 32'h0000BEEF);

    access(1, 0, 1, 12'd0, 16'h0001, 0);
    access(1, 1, 0, 12'd0, 16'h0000, 0);

    access(0, 1, 0, 12'd5, 16'h0000, 1);
    access(0, 1, 1, 12'd5, 16'h1234, 0);
    access(0, 1, 0, 12'd5, 16'h0000, 0);

    access(0, 0, 1, 12'd7, 16'hA5A5, 0);
    mr[0] = 1'b0; mw[0] = 1'b1; ad[0] = 12'd7; wd[0] = 16'h5555;
    @(posedge clk); #1;
    mw[0] = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rdy[0] || rdy[1]) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midwait_noready", {31'd0, seen}, 32'd0);
    exp_rd[0] = '0; exp_rd[1] = '0; exp_known[0] = 1'b1; exp_known[1] = 1'b1;
    check("midwait_rdata", {16'd0, rd_o[0]}, 32'd0);
    access(0, 1, 0, 12'd7, 16'h0000, 0);

    access(1, 0, 1, 12'd1023, 16'h3FF3, 0);
    access(1, 1, 0, 12'd1023, 16'h0000, 0);
    access(1, 0, 1, 12'd2000, 16'h7D07, 0);
    access(1, 1, 0, 12'd2000, 16'h0000, 0);
    access(1, 1, 0, 12'd1024, 16'h0000, 0);

    for (int n = 0; n < 120; n++) begin
      int k = n % 2;
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 15));
      p = $urandom_range(0, 9);
      access(k, (p == 0) || (p > 4), (p >= 1) && (p <= 4) || (p == 0), a,
             16'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
